cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller. It sits at the M stage and consumes the per-instruction PC, excCode and bd fields that the D→E→M pipeline registers carry.
- It produces IntReq, which flushes every pipeline register and redirects fetch to 0x0000_4180. It also produces EPC for eret and the mfc0 read data.
- It holds the SR, Cause, EPC and PrID registers.

Parameters:
- PRID, 32'h2021_1121, read-only PrID register value.
- EXC_NONE, 5'd31, excCode value meaning "no exception".
- EXC_INT, 5'd0, ExcCode recorded for an external interrupt.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at a posedge resets all state.
- PC_i  in  32  PC of the instruction currently in M.
- excCode_i  in  5  exception code of the M instruction; EXC_NONE = no exception.
- bd_i  in  1  M instruction sits in a branch delay slot.
- HWInt  in  6  external hardware interrupt lines, level-sensitive.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- EXLClr  in  1  eret in M; clears EXL.
- IntReq  out  1  take exception/interrupt this cycle (combinational).
- EPC_o  out  32  current EPC register value.
- DOut  out  32  mfc0 read data (combinational).

Behaviour:
- Register map:
  - 12 = SR: IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - 13 = Cause: BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - 14 = EPC: 32 bits.
  - 15 = PrID: reads PRID.
  - Any other A1 reads 0.
- Reset (reset==0 at posedge): IM=0, EXL=0, IE=0, BD=0, IP=0, ExcCode=0, EPC=0. Reset overrides every other event in the same cycle.
- IntReq = intPend | excPend, where:
  - intPend = |(HWInt & IM) & IE & ~EXL
  - excPend = (excCode_i != EXC_NONE) & ~EXL
- IntReq is purely combinational; zero-cycle latency from inputs. During reset the outputs reflect the register state; the pipeline ignores IntReq while reset is asserted.
- IP <= HWInt every non-reset cycle, independent of all other events.
- When IntReq=1 at posedge:
  - EXL <= 1.
  - BD <= bd_i.
  - ExcCode <= intPend ? EXC_INT : excCode_i. An interrupt has priority over a simultaneous synchronous exception.
  - EPC <= bd_i ? {PC_i[31:2],2'b00} - 4 : {PC_i[31:2],2'b00}.
  - Any mtc0 (WE) in the same cycle is suppressed.
  - Any EXLClr in the same cycle is ignored; EXL ends at 1.
- When IntReq=0 and WE=1:
  - A2=12: IM<=DIn[15:10], EXL<=DIn[1], IE<=DIn[0].
  - A2=14: EPC<=DIn.
  - Writes to 13, 15 or any other number are ignored.
- EXLClr=1 with IntReq=0: EXL<=0. If a WE to SR happens in the same cycle, EXLClr wins for the EXL bit only; IM and IE take DIn.
- DOut is a combinational mux on A1 of the current register values. A read in the same cycle as a write returns the old value; the new value is visible the next cycle.
- While EXL=1 no interrupt or exception is accepted (nested exceptions masked). excCode_i is ignored.
- EPC arithmetic is 32-bit unsigned with wrap: PC_i=0 with bd_i=1 gives EPC=32'hFFFF_FFFC.
- The module does not depend on stall. Bubbles inserted upstream carry EXC_NONE, and the pipeline keeps PC/bd on bubbles, so EPC is always meaningful.

Test Plan:
- Reset: hold reset=0 for 2 cycles with WE=1, A2=12, DIn=FFFF_FFFF → DOut reads 0 for A1=12, 13 and 14, reads 2021_1121 for A1=15; IntReq=0.
- mtc0 SR: write DIn=0000_FC01 to A2=12 → next cycle DOut(A1=12)=0000_FC01. Then HWInt=6'b000100 → IntReq=1 same cycle; after posedge Cause=0000_1000 (IP bit12, ExcCode 0), EXL=1, EPC=PC_i.
- Synchronous exception in delay slot: IE=0, excCode_i=12 (Ov), bd_i=1, PC_i=0000_3010 → IntReq=1; after posedge EPC=0000_300C, Cause=8000_0030, EXL=1.
- Masking under EXL: with EXL=1, apply excCode_i=4 and HWInt=3F → IntReq=0; Cause.ExcCode and EPC are unchanged. Then EXLClr=1 for one cycle → EXL=0, and with IM/IE still set IntReq rises the next cycle.
- Priority/collision: IE=1, IM=3F, HWInt=01 together with excCode_i=10, WE=1, A2=14, DIn=1234_5678 → ExcCode=0, EPC=PC_i (not 1234_5678).
- Reset mid-operation: with EXL=1 and EPC=0000_4000, drive reset=0 together with EXLClr=1 and excCode_i=5 → after posedge all fields are 0 and IntReq=0 with HWInt=0.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl - Coprocessor-0 exception/interrupt controller (M stage).
//
// Holds the SR, Cause, EPC and PrID registers. It decides combinationally
// whether the instruction in M takes an exception or an external interrupt
// (IntReq). It captures EPC/Cause on that event, and it services mtc0 writes
// and mfc0 reads.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-low reset
//   PC_i       PC of the instruction in M
//   excCode_i  exception code of the M instruction (EXC_NONE = none)
//   bd_i       M instruction is in a branch delay slot
//   HWInt      level-sensitive hardware interrupt lines
//   A1         mfc0 read register number
//   A2         mtc0 write register number
//   DIn        mtc0 write data
//   WE         mtc0 write enable
//   EXLClr     eret in M, clears EXL
//   IntReq     take exception/interrupt this cycle (combinational)
//   EPC_o      current EPC value
//   DOut       mfc0 read data (combinational)
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID     = 32'h2021_1121,
    parameter logic [4:0]  EXC_NONE = 5'd31,
    parameter logic [4:0]  EXC_INT  = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_i,
    input  logic [4:0]  excCode_i,
    input  logic        bd_i,
    input  logic [5:0]  HWInt,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC_o,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im_q,   im_d;
    logic        exl_q,  exl_d;
    logic        ie_q,   ie_d;
    logic        bd_q,   bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q,  exc_d;
    logic [31:0] epc_q,  epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] pc_aligned;
    logic [31:0] epc_capture;

    always_comb begin
        int_pend    = (|(HWInt & im_q)) & ie_q & ~exl_q;
        exc_pend    = (excCode_i != EXC_NONE) & ~exl_q;
        IntReq      = int_pend | exc_pend;
        pc_aligned  = {PC_i[31:2], 2'b00};
        // A delay-slot instruction restarts at its branch, one word earlier.
        epc_capture = bd_i ? (pc_aligned - 32'd4) : pc_aligned;
    end

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        if (IntReq) begin
            // Exception entry suppresses mtc0 and eret in the same cycle.
            exl_d = 1'b1;
            bd_d  = bd_i;
            exc_d = int_pend ? EXC_INT : excCode_i;
            epc_d = epc_capture;
        end else begin
            if (WE) begin
                if (A2 == REG_SR) begin
                    im_d  = DIn[15:10];
                    exl_d = DIn[1];
                    ie_d  = DIn[0];
                end else if (A2 == REG_EPC) begin
                    epc_d = DIn;
                end
            end
            // eret overrides an SR write for the EXL bit only.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= HWInt;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = {16'h0000, im_q, 8'h00, exl_q, ie_q};
            REG_CAUSE: DOut = {bd_q, 15'h0000, ip_q, 3'b000, exc_q, 2'b00};
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID;
            default:   DOut = '0;
        endcase
    end

    assign EPC_o = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_i;
    logic [4:0]  excCode_i;
    logic        bd_i;
    logic [5:0]  HWInt;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC_o;
    logic [31:0] DOut;

    int checks = 0;
    int errors = 0;

    cp0_exc_ctrl #(
        .PRID     (32'h2021_1121),
        .EXC_NONE (5'd31),
        .EXC_INT  (5'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PC_i      (PC_i),
        .excCode_i (excCode_i),
        .bd_i      (bd_i),
        .HWInt     (HWInt),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .EPC_o     (EPC_o),
        .DOut      (DOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
    endtask

    initial begin
        reset = 1'b0; PC_i = '0; excCode_i = 5'd31; bd_i = 1'b0; HWInt = '0;
        A1 = 5'd12; A2 = 5'd12; DIn = 32'hFFFF_FFFF; WE = 1'b1; EXLClr = 1'b0;

        // Reset held two cycles with a pending SR write
        tick(); tick();
        rd("rst_sr",    5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc",   5'd14, 32'h0);
        rd("rst_prid",  5'd15, 32'h2021_1121);
        rd("rst_other", 5'd16, 32'h0);
        chk("rst_intreq", {31'b0, IntReq}, 32'h0);

        // mtc0 SR
        reset = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        tick();
        WE = 1'b0;
        rd("sr_write", 5'd12, 32'h0000_FC01);
        chk("sr_noint", {31'b0, IntReq}, 32'h0);

        // External interrupt, unaligned PC
        HWInt = 6'b000100; PC_i = 32'h0000_2003;
        #1;
        chk("int_req", {31'b0, IntReq}, 32'h1);
        tick();
        rd("int_cause", 5'd13, 32'h0000_1000);
        rd("int_sr",    5'd12, 32'h0000_FC03);
        chk("int_epc", EPC_o, 32'h0000_2000);
        chk("int_exl_mask", {31'b0, IntReq}, 32'h0);

        // eret, then clear IE
        HWInt = '0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_FC01);
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
        tick();
        WE = 1'b0;

        // Synchronous exception in a delay slot
        excCode_i = 5'd12; bd_i = 1'b1; PC_i = 32'h0000_3010;
        #1;
        chk("exc_req", {31'b0, IntReq}, 32'h1);
        tick();
        excCode_i = 5'd31; bd_i = 1'b0;
        chk("exc_epc", EPC_o, 32'h0000_300C);
        rd("exc_cause", 5'd13, 32'h8000_0030);
        rd("exc_sr",    5'd12, 32'h0000_0002);

        // Masking under EXL: SR write keeps EXL=1
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03;
        tick();
        WE = 1'b0;
        excCode_i = 5'd4; HWInt = 6'h3F;
        #1;
        chk("mask_intreq", {31'b0, IntReq}, 32'h0);
        tick();
        rd("mask_cause", 5'd13, 32'h8000_FC30);
        chk("mask_epc", EPC_o, 32'h0000_300C);
        excCode_i = 5'd31; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        chk("eret_intreq", {31'b0, IntReq}, 32'h1);
        rd("eret2_sr", 5'd12, 32'h0000_FC01);

        // Priority/collision: interrupt beats exception and mtc0 EPC
        HWInt = 6'h01; excCode_i = 5'd10; WE = 1'b1; A2 = 5'd14;
        DIn = 32'h1234_5678; PC_i = 32'h0000_5004;
        rd("old_epc_read", 5'd14, 32'h0000_300C);
        tick();
        WE = 1'b0; excCode_i = 5'd31; HWInt = '0;
        chk("prio_epc", EPC_o, 32'h0000_5004);
        rd("prio_cause", 5'd13, 32'h0000_0400);

        // eret and SR write in one cycle: EXL cleared, IM/IE from DIn
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0003; EXLClr = 1'b1;
        tick();
        WE = 1'b0; EXLClr = 1'b0;
        rd("clr_vs_wr", 5'd12, 32'h0000_0001);

        // EPC wrap at PC 0 in a delay slot
        excCode_i = 5'd8; PC_i = 32'h0; bd_i = 1'b1;
        tick();
        excCode_i = 5'd31; bd_i = 1'b0;
        chk("wrap_epc", EPC_o, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0020);

        // Cause is not writable
        WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        rd("cause_ro", 5'd13, 32'h8000_0020);

        // Reset mid-operation
        A2 = 5'd14; DIn = 32'h0000_4000;
        tick();
        WE = 1'b0;
        chk("pre_rst_epc", EPC_o, 32'h0000_4000);
        reset = 1'b0; EXLClr = 1'b1; excCode_i = 5'd5;
        tick();
        reset = 1'b1; EXLClr = 1'b0; excCode_i = 5'd31;
        rd("mid_rst_sr",    5'd12, 32'h0);
        rd("mid_rst_cause", 5'd13, 32'h0);
        chk("mid_rst_epc", EPC_o, 32'h0);
        chk("mid_rst_intreq", {31'b0, IntReq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
